alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 150 +++++++++++++++
 tb/tb_alu_exec.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// ============================================================================
// Module   : alu_exec
// Brief    : Registered single-cycle ALU with an optional 32-iteration
//            shift-add multiplier enabled by macro ALU_ITER_MUL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        in_valid,
  input  logic [3:0]  ALUcon,
  input  logic        shift,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        zero,
  output logic        out_valid,
  output logic        busy
);

  localparam logic [3:0] c_op_add  = 4'b0000;
  localparam logic [3:0] c_op_sub  = 4'b0001;
  localparam logic [3:0] c_op_mul  = 4'b0010;
  localparam logic [3:0] c_op_ltz  = 4'b0011;
  localparam logic [3:0] c_op_gtz  = 4'b0100;
  localparam logic [3:0] c_op_lez  = 4'b0101;
  localparam logic [3:0] c_op_and  = 4'b1000;
  localparam logic [3:0] c_op_or   = 4'b1001;
  localparam logic [3:0] c_op_nor  = 4'b1010;
  localparam logic [3:0] c_op_xor  = 4'b1011;
  localparam logic [3:0] c_op_sll  = 4'b1100;
  localparam logic [3:0] c_op_srl  = 4'b1101;
  localparam logic [3:0] c_op_slt  = 4'b1110;

  logic        w_accept;
  logic        w_mul_start;
  logic        w_mul_last;
  logic [31:0] w_mul_res;
  logic [4:0]  w_sh_amt;
  logic [31:0] w_alu;

  assign w_accept = in_valid & ~busy;
  assign w_sh_amt = shift ? shamt : A[4:0];

  always_comb begin
    w_alu = 32'd0;
    case (ALUcon)
      c_op_add: w_alu = A + B;
      c_op_sub: w_alu = A - B;
      c_op_ltz: w_alu = {31'd0, ($signed(A) <  32'sd0)};
      c_op_gtz: w_alu = {31'd0, ($signed(A) >  32'sd0)};
      c_op_lez: w_alu = {31'd0, ($signed(A) <= 32'sd0)};
      c_op_and: w_alu = A & B;
      c_op_or:  w_alu = A | B;
      c_op_nor: w_alu = ~(A | B);
      c_op_xor: w_alu = A ^ B;
      c_op_sll: w_alu = B << w_sh_amt;
      c_op_srl: w_alu = B >> w_sh_amt;
      c_op_slt: w_alu = {31'd0, ($signed(A) < $signed(B))};
      default:  w_alu = 32'd0;
    endcase
  end

`ifdef ALU_ITER_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;

  assign w_mul_start = w_accept & (ALUcon == c_op_mul);
  assign w_mul_last  = (r_state == S_MUL) && (r_cnt == 5'd31);
  assign w_mul_res   = r_acc + (r_mplier[0] ? r_mcand : 32'd0);
  assign busy        = (r_state == S_MUL);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_mul_start) w_state_next = S_MUL;
      S_MUL:   if (r_cnt == 5'd31) w_state_next = S_DONE;
      S_DONE:  w_state_next = w_mul_start ? S_MUL : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Multiplicand walks left, multiplier walks right; low 32 bits accumulate.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt    <= 5'd0;
      r_acc    <= 32'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
    end else if (w_mul_start) begin
      r_cnt    <= 5'd0;
      r_acc    <= 32'd0;
      r_mcand  <= A;
      r_mplier <= B;
    end else if (r_state == S_MUL) begin
      r_cnt    <= r_cnt + 5'd1;
      r_acc    <= w_mul_res;
      r_mcand  <= {r_mcand[30:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[31:1]};
    end
  end
`else
  assign w_mul_start = 1'b0;
  assign w_mul_last  = 1'b0;
  assign w_mul_res   = 32'd0;
  assign busy        = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      result    <= 32'd0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else if (w_accept && !w_mul_start) begin
      result    <= w_alu;
      zero      <= (w_alu == 32'd0);
      out_valid <= 1'b1;
    end else if (w_mul_last) begin
      result    <= w_mul_res;
      zero      <= (w_mul_res == 32'd0);
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
// Module   : tb_alu_exec
// Brief    : Directed self-checking bench for alu_exec (both macro builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec;

  logic        Clk;
  logic        Rst_n;
  logic        in_valid;
  logic [3:0]  ALUcon;
  logic        shift;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        zero;
  logic        out_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  alu_exec dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .in_valid  (in_valid),
    .ALUcon    (ALUcon),
    .shift     (shift),
    .A         (A),
    .B         (B),
    .shamt     (shamt),
    .result    (result),
    .zero      (zero),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Present one request for one cycle; returns #1 after the accepting edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic sh, input logic [4:0] sa);
    @(negedge Clk);
    in_valid = 1'b1;
    ALUcon   = op;
    A        = a;
    B        = b;
    shift    = sh;
    shamt    = sa;
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic sh, input logic [4:0] sa,
                          input logic [31:0] exp);
    run_op(op, a, b, sh, sa);
    check({tag, "_res"}, result, exp);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
    check({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    int busy_cnt;
    int ov_cnt;

    Rst_n    = 1'b0;
    in_valid = 1'b0;
    ALUcon   = 4'd0;
    shift    = 1'b0;
    A        = 32'd0;
    B        = 32'd0;
    shamt    = 5'd0;

    repeat (3) @(posedge Clk);
    #1;
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    op_check("add_7_5", 4'b0000, 32'd7, 32'd5, 1'b0, 5'd0, 32'd12);
    @(posedge Clk);
    #1;
    check("add_ov_pulse", {31'd0, out_valid}, 32'd0);
    check("add_hold", result, 32'd12);

    op_check("sub_5_5",   4'b0001, 32'd5, 32'd5, 1'b0, 5'd0, 32'd0);
    op_check("sub_wrap",  4'b0001, 32'd0, 32'd1, 1'b0, 5'd0, 32'hFFFF_FFFF);
    op_check("add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0, 32'd0);
    op_check("slt_neg",   4'b1110, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd0, 32'd1);
    op_check("slt_pos",   4'b1110, 32'd1, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    op_check("ltz",       4'b0011, 32'h8000_0000, 32'd0, 1'b0, 5'd0, 32'd1);
    op_check("gtz_zero",  4'b0100, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    op_check("gtz_pos",   4'b0100, 32'd9, 32'd0, 1'b0, 5'd0, 32'd1);
    op_check("lez_zero",  4'b0101, 32'd0, 32'd0, 1'b0, 5'd0, 32'd1);
    op_check("and",       4'b1000, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 5'd0, 32'h00F0_1200);
    op_check("or",        4'b1001, 32'hF000_0001, 32'h0000_0F00, 1'b0, 5'd0, 32'hF000_0F01);
    op_check("nor",       4'b1010, 32'd0, 32'd0, 1'b0, 5'd0, 32'hFFFF_FFFF);
    op_check("xor",       4'b1011, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 5'd0, 32'h5555_5555);
    op_check("sll_shamt", 4'b1100, 32'd0, 32'd1, 1'b1, 5'd4, 32'h10);
    op_check("srl_31",    4'b1101, 32'd0, 32'h8000_0000, 1'b1, 5'd31, 32'd1);
    op_check("sll_a_amt", 4'b1100, 32'hFFFF_FFE3, 32'd1, 1'b0, 5'd31, 32'h8);
    op_check("srl_a_amt", 4'b1101, 32'd8, 32'hFF00_0000, 1'b0, 5'd1, 32'h00FF_0000);
    op_check("undef_0110", 4'b0110, 32'd7, 32'd5, 1'b0, 5'd0, 32'd0);
    op_check("undef_1111", 4'b1111, 32'd7, 32'd5, 1'b0, 5'd0, 32'd0);

`ifdef ALU_ITER_MUL_EN
    // Long multiply with a competing add held on the inputs the whole time.
    @(negedge Clk);
    in_valid = 1'b1;
    ALUcon   = 4'b0010;
    A        = 32'h0001_0001;
    B        = 32'h0001_0001;
    @(posedge Clk);
    #1;
    ALUcon   = 4'b0000;
    A        = 32'd1;
    B        = 32'd2;
    busy_cnt = 0;
    ov_cnt   = 0;
    if (busy) busy_cnt++;
    if (out_valid) ov_cnt++;
    for (int k = 2; k <= 32; k++) begin
      @(posedge Clk);
      #1;
      if (busy) busy_cnt++;
      if (out_valid) ov_cnt++;
    end
    check("mul_busy_cycles", busy_cnt, 32'd32);
    check("mul_ov_early", ov_cnt, 32'd0);
    @(posedge Clk);
    #1;
    check("mul_ov", {31'd0, out_valid}, 32'd1);
    check("mul_busy_done", {31'd0, busy}, 32'd0);
    check("mul_res", result, 32'h0002_0001);
    check("mul_zero", {31'd0, zero}, 32'd0);
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    check("b2b_ov", {31'd0, out_valid}, 32'd1);
    check("b2b_res", result, 32'd3);

    run_op(4'b0010, 32'h1234_5678, 32'd9, 1'b0, 5'd0);
    repeat (32) @(posedge Clk);
    #1;
    check("mul2_ov", {31'd0, out_valid}, 32'd1);
    check("mul2_res", result, 32'hA3D7_0A38);

    run_op(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd0);
    repeat (32) @(posedge Clk);
    #1;
    check("mul3_res", result, 32'd1);

    // Abort a multiply with reset part way through.
    run_op(4'b0010, 32'd3, 32'd4, 1'b0, 5'd0);
    repeat (9) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ov", {31'd0, out_valid}, 32'd0);
    check("abort_res", result, 32'd0);
    check("abort_zero", {31'd0, zero}, 32'd1);
    @(negedge Clk);
    Rst_n  = 1'b1;
    ov_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk);
      #1;
      if (out_valid) ov_cnt++;
    end
    check("abort_no_pulse", ov_cnt, 32'd0);
    op_check("post_abort_add", 4'b0000, 32'd1, 32'd1, 1'b0, 5'd0, 32'd2);
`else
    op_check("mul_undef", 4'b0010, 32'd3, 32'd4, 1'b0, 5'd0, 32'd0);
    check("mul_undef_busy", {31'd0, busy}, 32'd0);
    @(posedge Clk);
    #1;
    check("mul_undef_busy2", {31'd0, busy}, 32'd0);
    check("mul_undef_pulse", {31'd0, out_valid}, 32'd0);

    op_check("pre_rst_add", 4'b0000, 32'd20, 32'd22, 1'b0, 5'd0, 32'd42);
    #1;
    Rst_n = 1'b0;
    #1;
    check("async_rst_res", result, 32'd0);
    check("async_rst_ov", {31'd0, out_valid}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    op_check("post_rst_add", 4'b0000, 32'd1, 32'd1, 1'b0, 5'd0, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
